// File: rtl/sens_frame_rx_if.sv
// Sensor link bundle: oversample tick and serial line in,
// validated sample, strobes and error count out.
interface sens_frame_rx_if;
  logic        clk_en_i;
  logic        sens_in_i;
  logic [15:0] sens_data_o;
  logic        sens_write_data_o;
  logic        frame_err_o;
  logic [7:0]  err_cnt_o;

  modport master (
    output clk_en_i,
    output sens_in_i,
    input  sens_data_o,
    input  sens_write_data_o,
    input  frame_err_o,
    input  err_cnt_o
  );

  modport slave (
    input  clk_en_i,
    input  sens_in_i,
    output sens_data_o,
    output sens_write_data_o,
    output frame_err_o,
    output err_cnt_o
  );
endinterface

// File: rtl/sens_frame_rx.sv
// Sensor UART (8N1) receiver and 4-byte frame validator:
// sync, hi, lo, hi^lo checksum.
module sens_frame_rx #(
  parameter int          OVERSAMPLE = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic            clk_in_i,
  input  logic            reset_i,
  sens_frame_rx_if.slave  bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_t;
  typedef enum logic [1:0] {F_SYNC, F_HI, F_LO, F_CHK} frame_t;

  logic          sync1, sync2;
  byte_t         bst, bst_nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic [2:0]    bidx, bidx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          rx_ok, rx_bad;
  frame_t        fst, fst_nxt;
  logic [7:0]    hi, hi_nxt;
  logic [7:0]    lo, lo_nxt;
  logic          wr_nxt, err_nxt;

  always_ff @(posedge clk_in_i or posedge reset_i) begin
    if (reset_i) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      bst   <= IDLE;
      tick  <= '0;
      bidx  <= '0;
      shreg <= '0;
      fst   <= F_SYNC;
      hi    <= '0;
      lo    <= '0;
      bus.sens_data_o       <= '0;
      bus.sens_write_data_o <= 1'b0;
      bus.frame_err_o       <= 1'b0;
      bus.err_cnt_o         <= '0;
    end else begin
      sync1 <= bus.sens_in_i;
      sync2 <= sync1;
      bst   <= bst_nxt;
      tick  <= tick_nxt;
      bidx  <= bidx_nxt;
      shreg <= shreg_nxt;
      fst   <= fst_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      bus.sens_write_data_o <= wr_nxt;
      bus.frame_err_o       <= err_nxt;
      if (wr_nxt)
        bus.sens_data_o <= {hi, lo};
      if (err_nxt && bus.err_cnt_o != 8'hFF)
        bus.err_cnt_o <= bus.err_cnt_o + 8'd1;
    end
  end

  // Stop bit is judged at its centre; returning to IDLE there
  // leaves half a bit to catch an abutting start edge.
  always_comb begin
    bst_nxt   = bst;
    tick_nxt  = tick;
    bidx_nxt  = bidx;
    shreg_nxt = shreg;
    rx_ok     = 1'b0;
    rx_bad    = 1'b0;
    if (bus.clk_en_i) begin
      unique case (bst)
        IDLE: begin
          if (!sync2) begin
            bst_nxt  = START;
            tick_nxt = '0;
          end
        end
        START: begin
          if (tick == T_MID) begin
            tick_nxt = '0;
            bidx_nxt = '0;
            bst_nxt  = sync2 ? IDLE : DATA;
          end else begin
            tick_nxt = tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == T_END) begin
            tick_nxt  = '0;
            shreg_nxt = {sync2, shreg[7:1]};
            bidx_nxt  = bidx + 3'd1;
            if (bidx == 3'd7)
              bst_nxt = STOP;
          end else begin
            tick_nxt = tick + 1'b1;
          end
        end
        STOP: begin
          if (tick == T_END) begin
            tick_nxt = '0;
            rx_ok    = sync2;
            rx_bad   = !sync2;
            bst_nxt  = IDLE;
          end else begin
            tick_nxt = tick + 1'b1;
          end
        end
        default: bst_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    fst_nxt = fst;
    hi_nxt  = hi;
    lo_nxt  = lo;
    wr_nxt  = 1'b0;
    err_nxt = 1'b0;
    if (rx_bad) begin
      if (fst != F_SYNC) begin
        err_nxt = 1'b1;
        fst_nxt = F_SYNC;
      end
    end else if (rx_ok) begin
      unique case (fst)
        F_SYNC: if (shreg == SYNC_BYTE) fst_nxt = F_HI;
        F_HI: begin
          hi_nxt  = shreg;
          fst_nxt = F_LO;
        end
        F_LO: begin
          lo_nxt  = shreg;
          fst_nxt = F_CHK;
        end
        F_CHK: begin
          if (shreg == (hi ^ lo))
            wr_nxt = 1'b1;
          else
            err_nxt = 1'b1;
          fst_nxt = F_SYNC;
        end
        default: fst_nxt = F_SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_sens_frame_rx.sv
// Directed bench: OVERSAMPLE=16 instance for framing cases,
// OVERSAMPLE=4 instance for error-counter saturation.
module tb_sens_frame_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;

  sens_frame_rx_if bm ();
  sens_frame_rx_if bs ();

  sens_frame_rx #(
    .OVERSAMPLE (16),
    .SYNC_BYTE  (8'hA5)
  ) u_dut (
    .clk_in_i (clk),
    .reset_i  (rst),
    .bus      (bm.slave)
  );

  sens_frame_rx #(
    .OVERSAMPLE (4),
    .SYNC_BYTE  (8'hA5)
  ) u_sat (
    .clk_in_i (clk),
    .reset_i  (rst),
    .bus      (bs.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int   m_wr = 0, m_err = 0, s_wr = 0, s_err = 0;
  int   wide = 0, both = 0;
  logic m_wr_q = 1'b0, m_err_q = 1'b0;
  logic s_wr_q = 1'b0, s_err_q = 1'b0;

  always @(negedge clk) begin
    if (bm.sens_write_data_o) m_wr <= m_wr + 1;
    if (bm.frame_err_o)       m_err <= m_err + 1;
    if (bs.sens_write_data_o) s_wr <= s_wr + 1;
    if (bs.frame_err_o)       s_err <= s_err + 1;
    if ((bm.sens_write_data_o && m_wr_q) ||
        (bm.frame_err_o && m_err_q) ||
        (bs.sens_write_data_o && s_wr_q) ||
        (bs.frame_err_o && s_err_q))
      wide <= wide + 1;
    if ((bm.sens_write_data_o && bm.frame_err_o) ||
        (bs.sens_write_data_o && bs.frame_err_o))
      both <= both + 1;
    m_wr_q  <= bm.sens_write_data_o;
    m_err_q <= bm.frame_err_o;
    s_wr_q  <= bs.sens_write_data_o;
    s_err_q <= bs.frame_err_o;
  end

  // main instance: tick every second cycle, so a bit is 32 cycles
  initial begin
    bm.clk_en_i = 1'b0;
    forever begin
      @(negedge clk);
      bm.clk_en_i = ~bm.clk_en_i;
    end
  end

  task automatic m_bit(input logic v);
    bm.sens_in_i = v;
    repeat (32) @(negedge clk);
  endtask

  task automatic m_idle(input int n);
    for (int i = 0; i < n; i++) m_bit(1'b1);
  endtask

  task automatic m_byte(input logic [7:0] b, input logic stop);
    m_bit(1'b0);
    for (int i = 0; i < 8; i++) m_bit(b[i]);
    m_bit(stop);
  endtask

  task automatic m_frame(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    m_byte(a, 1'b1);
    m_byte(b, 1'b1);
    m_byte(c, 1'b1);
    m_byte(d, 1'b1);
  endtask

  task automatic s_byte(input logic [7:0] b);
    logic [9:0] sh;
    sh = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bs.sens_in_i = sh[i];
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic s_frame;
    s_byte(8'hA5);
    s_byte(8'h56);
    s_byte(8'h78);
    s_byte(8'h00);
  endtask

  int w0, e0;

  initial begin
    bm.sens_in_i = 1'b1;
    bs.sens_in_i = 1'b1;
    bs.clk_en_i  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", bm.sens_data_o, 32'h0);
    chk("rst_wr",   bm.sens_write_data_o, 32'h0);
    chk("rst_err",  bm.frame_err_o, 32'h0);
    chk("rst_cnt",  bm.err_cnt_o, 32'h0);
    rst = 1'b0;
    m_idle(2);

    w0 = m_wr; e0 = m_err;
    m_frame(8'hA5, 8'h12, 8'h34, 8'h26);
    m_idle(2);
    chk("valid_data", bm.sens_data_o, 32'h1234);
    chk("valid_wr",   m_wr - w0, 1);
    chk("valid_err",  m_err - e0, 0);
    chk("valid_cnt",  bm.err_cnt_o, 0);

    w0 = m_wr; e0 = m_err;
    m_frame(8'hA5, 8'h56, 8'h78, 8'h00);
    m_idle(2);
    chk("cksum_data", bm.sens_data_o, 32'h1234);
    chk("cksum_wr",   m_wr - w0, 0);
    chk("cksum_err",  m_err - e0, 1);
    chk("cksum_cnt",  bm.err_cnt_o, 1);

    w0 = m_wr; e0 = m_err;
    m_byte(8'h00, 1'b1);
    m_byte(8'hFF, 1'b1);
    m_byte(8'h3C, 1'b1);
    m_frame(8'hA5, 8'hBE, 8'hEF, 8'h51);
    m_idle(2);
    chk("junk_data", bm.sens_data_o, 32'hBEEF);
    chk("junk_wr",   m_wr - w0, 1);
    chk("junk_err",  m_err - e0, 0);
    chk("junk_cnt",  bm.err_cnt_o, 1);

    w0 = m_wr; e0 = m_err;
    m_byte(8'hA5, 1'b1);
    m_byte(8'h11, 1'b1);
    m_byte(8'h22, 1'b0);
    m_idle(12);
    chk("ferr_data", bm.sens_data_o, 32'hBEEF);
    chk("ferr_wr",   m_wr - w0, 0);
    chk("ferr_err",  m_err - e0, 1);
    chk("ferr_cnt",  bm.err_cnt_o, 2);
    w0 = m_wr;
    m_frame(8'hA5, 8'h00, 8'h01, 8'h01);
    m_idle(2);
    chk("after_ferr_data", bm.sens_data_o, 32'h0001);
    chk("after_ferr_wr",   m_wr - w0, 1);

    w0 = m_wr; e0 = m_err;
    bm.sens_in_i = 1'b0;
    repeat (6) @(negedge clk);
    bm.sens_in_i = 1'b1;
    m_idle(3);
    chk("glitch_wr",  m_wr - w0, 0);
    chk("glitch_err", m_err - e0, 0);
    chk("glitch_cnt", bm.err_cnt_o, 2);

    m_byte(8'hA5, 1'b1);
    m_byte(8'h12, 1'b1);
    m_idle(1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_data", bm.sens_data_o, 32'h0);
    chk("midrst_wr",   bm.sens_write_data_o, 32'h0);
    chk("midrst_err",  bm.frame_err_o, 32'h0);
    chk("midrst_cnt",  bm.err_cnt_o, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    w0 = m_wr; e0 = m_err;
    m_byte(8'h34, 1'b1);
    m_byte(8'h26, 1'b1);
    m_idle(2);
    chk("orphan_wr",  m_wr - w0, 0);
    chk("orphan_err", m_err - e0, 0);
    chk("orphan_cnt", bm.err_cnt_o, 0);
    m_frame(8'hA5, 8'h12, 8'h34, 8'h26);
    m_idle(2);
    chk("post_rst_data", bm.sens_data_o, 32'h1234);
    chk("post_rst_wr",   m_wr - w0, 1);

    e0 = s_err; w0 = s_wr;
    for (int k = 0; k < 300; k++) begin
      s_frame();
      if (k == 253 || k == 254) begin
        repeat (8) @(negedge clk);
        chk("sat_cnt_edge", bs.err_cnt_o, k + 1);
      end
    end
    repeat (8) @(negedge clk);
    chk("sat_cnt",    bs.err_cnt_o, 255);
    chk("sat_pulses", s_err - e0, 300);
    chk("sat_wr",     s_wr - w0, 0);

    chk("strobe_width", wide, 0);
    chk("strobe_both",  both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
